// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: merges stage stall requests and sequences PC redirects with flush strobes.
// Optional trap path enabled by defining PC_CTRL_TRAP_EN.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        ex_br,
  input  logic [31:0] ex_br_addr,
  input  logic        trap_req,
  input  logic [31:0] trap_addr,
  output logic [5:0]  stall,
  output logic        br,
  output logic [31:0] br_addr,
  output logic [5:0]  flush,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_t;
  state_t state_q, state_d;
  logic br_q, br_d, trap_go, br_go;
  logic [31:0] br_addr_q, br_addr_d;
  logic [5:0] flush_q, flush_d;
`ifdef PC_CTRL_TRAP_EN
  assign trap_go = trap_req;
`else
  logic unused_trap;
  assign unused_trap = trap_req;
  assign trap_go = 1'b0;
`endif
  always_comb begin
    stall = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
            stallreq_id  ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    // a branch seen outside IDLE is on the wrong path and is dropped
    br_go = ex_br & ~stall[3] & (state_q == IDLE);
    state_d = (trap_go | br_go) ? REDIR :
              (state_q == REDIR) ? DRAIN :
              (state_q == DRAIN && !stall[0]) ? IDLE : state_q;
    br_addr_d = trap_go ? trap_addr : br_go ? ex_br_addr : RESET_VEC;
    br_d = (state_d == REDIR);
    flush_d = (state_d == REDIR) ? 6'b000110 : (state_d == DRAIN) ? 6'b000010 : 6'b000000;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      br_q      <= 1'b0;
      br_addr_q <= RESET_VEC;
      flush_q   <= 6'b000000;
    end else begin
      state_q   <= state_d;
      br_q      <= br_d;
      br_addr_q <= br_addr_d;
      flush_q   <= flush_d;
    end
  end
  assign br      = br_q;
  assign br_addr = br_addr_q;
  assign flush   = flush_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed test-plan sequences plus random traffic against a behavioural model.
module tb_pc_redirect_ctrl;
  localparam logic [31:0] RV = 32'h0000_0004;
`ifdef PC_CTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
  logic ex_br = 0, trap_req = 0;
  logic [31:0] ex_br_addr = 0, trap_addr = 0;
  logic [5:0] stall, flush;
  logic br, busy;
  logic [31:0] br_addr;
  int checks = 0, failures = 0;
  logic m_br, m_busy;
  logic [31:0] m_addr;

  pc_redirect_ctrl #(.RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem), .ex_br(ex_br),
    .ex_br_addr(ex_br_addr), .trap_req(trap_req), .trap_addr(trap_addr),
    .stall(stall), .br(br), .br_addr(br_addr), .flush(flush), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // oldest requester wins: all stages up to and including it are frozen
  function automatic logic [5:0] ref_stall();
    int lvl;
    lvl = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
    return 6'((1 << lvl) - 1);
  endfunction

  function automatic logic [5:0] ref_flush();
    return m_br ? 6'b000110 : m_busy ? 6'b000010 : 6'b000000;
  endfunction

  task automatic check_all();
    chk("stall", 32'(stall), 32'(ref_stall()));
    chk("br", 32'(br), 32'(m_br));
    chk("br_addr", br_addr, m_addr);
    chk("flush", 32'(flush), 32'(ref_flush()));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic model_reset();
    m_br = 0; m_busy = 0; m_addr = RV;
  endtask

  task automatic model_step();
    logic [5:0] st;
    logic tk_trap, tk_br;
    st = ref_stall();
    tk_trap = TRAP && trap_req;
    tk_br = !m_busy && ex_br && !st[3];
    if (tk_trap || tk_br) begin
      m_br = 1; m_busy = 1; m_addr = tk_trap ? trap_addr : ex_br_addr;
    end else if (m_br) begin
      m_br = 0; m_addr = RV;
    end else if (m_busy && !st[0]) m_busy = 0;
  endtask

  // sr = {mem, ex, id, if}
  task automatic cyc(input logic [3:0] sr, input logic eb, input logic [31:0] ea,
                     input logic tr, input logic [31:0] ta);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = sr;
    ex_br = eb; ex_br_addr = ea; trap_req = tr; trap_addr = ta;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    stallreq_mem = 1;
    model_reset();
    #2;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h1f);
    chk("rst_br", 32'(br), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_addr", br_addr, RV);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 0;
    stallreq_mem = 0;
    // stall priority
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0101;
    #1 chk("prio_if_ex", 32'(stall), 32'h0f);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0010;
    #1 chk("prio_id", 32'(stall), 32'h07);
    cyc(4'b0010, 0, 0, 0, 0);
    // plain branch
    cyc(4'b0000, 1, 32'h100, 0, 0);
    chk("n1_br", 32'(br), 1);
    chk("n1_addr", br_addr, 32'h100);
    chk("n1_flush", 32'(flush), 32'h06);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("n2_flush", 32'(flush), 32'h02);
    chk("n2_br", 32'(br), 0);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("n3_busy", 32'(busy), 0);
    // branch blocked by EX stall, then released
    cyc(4'b0100, 1, 32'h200, 0, 0);
    chk("blk_br", 32'(br), 0);
    cyc(4'b0000, 1, 32'h200, 0, 0);
    chk("rel_br", 32'(br), 1);
    chk("rel_addr", br_addr, 32'h200);
    cyc(4'b0000, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    // DRAIN held by IF stall
    cyc(4'b0000, 1, 32'h300, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0001, 0, 0, 0, 0);
      chk("drain_flush", 32'(flush), 32'h02);
      chk("drain_busy", 32'(busy), 1);
    end
    cyc(4'b0000, 0, 0, 0, 0);
    chk("drain_exit", 32'(busy), 0);
    // trap during DRAIN
    cyc(4'b0000, 1, 32'h400, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 1, 32'h80);
    chk("trap_br", 32'(br), 32'(TRAP));
    if (br) chk("trap_addr", br_addr, 32'h80);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 0, 0, 0, 0);
    // reset aborts an in-flight redirect
    cyc(4'b0000, 1, 32'h500, 0, 0);
    do_reset();
    chk("abort_br", 32'(br), 0);
    for (int i = 0; i < 2; i++) cyc(4'b0000, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      cyc({($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0)},
          ($urandom_range(0, 2) == 0), $urandom,
          ($urandom_range(0, 9) == 0), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Pipeline controller that sequences the program counter and fetch/decode stages. It merges per-stage stall requests into the 6-bit `stall` vector consumed by the PC and pipeline registers. It arbitrates control-flow redirects (EX-stage branch/jump, optional trap) into a single one-cycle `br`/`br_addr` pulse to the PC, and generates flush strobes that kill wrong-path instructions until the redirected fetch is in flight. It sits beside the PC, fed by the EX and MEM stage outputs.

## Interface
Parameters:
- `RESET_VEC`, 32'h0000_0004: value driven on `br_addr` while idle and out of reset.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `stallreq_if`  in  1  IF stage requests stall.
- `stallreq_id`  in  1  ID stage requests stall.
- `stallreq_ex`  in  1  EX stage requests stall (multi-cycle op).
- `stallreq_mem`  in  1  MEM stage requests stall (memory wait).
- `ex_br`  in  1  EX resolved taken branch/jump.
- `ex_br_addr`  in  `InstAddrBus`  branch target.
- `trap_req`  in  1  trap/exception request (only with `PC_CTRL_TRAP_EN`).
- `trap_addr`  in  `InstAddrBus`  trap vector.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `br`  out  1  redirect strobe to PC, registered.
- `br_addr`  out  `InstAddrBus`  redirect target, registered.
- `flush`  out  6  per-stage kill, same bit mapping as `stall`, registered.
- `busy`  out  1  state != IDLE.

## Operation
- Stall vector (combinational from requests, oldest requester wins): mem -> 6'b011111; else ex -> 6'b001111; else id -> 6'b000111; else if -> 6'b000011; else 6'b000000. Bit5 never set.
- Redirect acceptance in cycle N: trap (if enabled) is accepted in any state; `ex_br` is accepted only when `stall[3]==0` and state is IDLE. Trap beats `ex_br` in the same cycle. `ex_br` during REDIR/DRAIN is ignored, because the instruction is wrong-path.
- FSM:
  - IDLE: on acceptance, go to REDIR and latch the target.
  - REDIR: `br=1` and `br_addr`=target for exactly one cycle, `flush=6'b000110` (IF, ID). Go to DRAIN.
  - DRAIN: `flush=6'b000010` (kills the stale `pc_o` the PC emits one cycle after `br`). Stay while `stall[0]==1`. When `stall[0]==0`, go to IDLE.
  - A trap in REDIR or DRAIN re-latches the target and returns to REDIR.
- `br` is issued regardless of `stall`, since the PC takes `br` unconditionally.
- Reset values: state IDLE, `br=0`, `br_addr=RESET_VEC`, `flush=0`, `busy=0`. `stall` follows its inputs, including during reset.
- Reset asserted mid-REDIR/DRAIN aborts the redirect immediately. No `br` is emitted after reset release until a new acceptance.

## Timing
- Stall: 0-cycle latency, combinational.
- Redirect: accepted at edge N; `br` is high in cycle N+1 only; DRAIN starts in N+2 (minimum), and IDLE is reached in N+3 at the earliest.
- Minimum spacing between two `br` pulses: 3 cycles for `ex_br`, 1 cycle for trap preemption.
- `flush` and `br` change only on `clk` edges. No combinational path from the redirect inputs to them.

## Configuration
- `PC_CTRL_TRAP_EN` defined: the trap path is active. `trap_req` has top priority and can preempt REDIR/DRAIN.
- `PC_CTRL_TRAP_EN` undefined: `trap_req` and `trap_addr` are ignored (ports remain, unused). Only `ex_br` redirects, and REDIR/DRAIN are never preempted.

## Test plan
- Reset: hold `rst=1` with `stallreq_mem=1`. Expect `stall=6'b011111`, `br=0`, `flush=0`, `br_addr=RESET_VEC`, `busy=0`.
- Stall priority: assert if+ex together, expect `stall=6'b001111`. Assert id alone, expect `6'b000111`.
- Branch: `ex_br=1`, `ex_br_addr=32'h100` at cycle N, stalls low. Expect:
  - `br=1`, `br_addr=32'h100`, `flush=6'b000110` at N+1;
  - `flush=6'b000010` at N+2;
  - `busy=0` at N+3.
- Blocked branch: `ex_br=1` with `stallreq_ex=1`, expect no `br`. Drop the stall with `ex_br` held, expect `br` the following cycle.
- DRAIN under stall: branch accepted, then `stallreq_if=1` for 3 cycles from N+2. Expect `flush=6'b000010` held through all 3 cycles, then IDLE one cycle after the stall clears.
- Trap preemption (`PC_CTRL_TRAP_EN`): at N+2 (DRAIN) assert `trap_req`, `trap_addr=32'h80`. Expect `br=1`, `br_addr=32'h80` at N+3. Repeat without the macro and expect no second `br`.
